// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: reset vector, PC step,
// jump-index width and the redirect-source encoding used by the fetch stage.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam int          JUMP_IDX_W       = 26;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP,
    RD_PENDING
  } redirect_src_e;

  // Instruction addresses are word aligned; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational next-PC selection: branch beats jump beats a held redirect,
// otherwise sequential fetch. Also derives the IF/ID squash request.
module pc_redirect_sel
  import mips_pkg::*;
(
  input  logic [31:0]           pc,
  input  logic                  pc_write,
  input  logic                  in_reset,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  jump,
  input  logic [JUMP_IDX_W-1:0] jump_index,
  input  logic [3:0]            jump_pc_hi,
  input  logic                  pending_valid,
  input  logic [31:0]           pending_target,
  output logic [31:0]           pc_plus4,
  output logic [31:0]           next_pc,
  output logic                  new_redirect,
  output logic [31:0]           new_target,
  output redirect_src_e         redirect_src,
  output logic                  if_flush
);

  logic [31:0] jump_target;
  logic [31:0] br_target;
  logic        unused_br_low;

  assign jump_target   = {jump_pc_hi, jump_index, 2'b00};
  assign br_target     = word_align(branch_target);
  assign unused_br_low = ^branch_target[1:0];

  assign pc_plus4      = pc + PC_INC;
  assign new_redirect  = branch_taken | jump;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    redirect_src = RD_NONE;
    new_target   = pc_plus4;
    next_pc      = pc_plus4;
    if (branch_taken) begin
      redirect_src = RD_BRANCH;
      new_target   = br_target;
    end else if (jump) begin
      redirect_src = RD_JUMP;
      new_target   = jump_target;
    end else if (pending_valid) begin
      redirect_src = RD_PENDING;
    end

    unique case (redirect_src)
      RD_BRANCH, RD_JUMP: next_pc = new_target;
      RD_PENDING:         next_pc = pending_target;
      default:            next_pc = pc_plus4;
    endcase
  end

  // IF/ID holds during a stall, so a squash only makes sense when the PC moves.
  assign if_flush = pc_write & ~in_reset & (redirect_src != RD_NONE);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, applies ID-resolved
// redirects, holds under load-use stalls and remembers redirects seen while stalled.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  PCWrite,
  input  logic                  BranchTaken,
  input  logic [31:0]           BranchTarget,
  input  logic                  Jump,
  input  logic [JUMP_IDX_W-1:0] JumpIndex,
  input  logic [3:0]            JumpPCHi,
  output logic [31:0]           PC,
  output logic [IMEM_AW-1:0]    ImemAddr,
  output logic [31:0]           PCplus4,
  output logic                  IF_flush,
  output logic [31:0]           FetchCount,
  output logic [15:0]           RedirectCount
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]   pc_q;
  logic          pending_valid;
  logic [31:0]   pending_target;
  logic [31:0]   fetch_count;
  logic [15:0]   redirect_count;

  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;
  logic          new_redirect;
  logic [31:0]   new_target;
  redirect_src_e redirect_src;
  logic          if_flush;

  pc_redirect_sel u_sel (
    .pc             (pc_q),
    .pc_write       (PCWrite),
    .in_reset       (~reset_n),
    .branch_taken   (BranchTaken),
    .branch_target  (BranchTarget),
    .jump           (Jump),
    .jump_index     (JumpIndex),
    .jump_pc_hi     (JumpPCHi),
    .pending_valid  (pending_valid),
    .pending_target (pending_target),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .new_redirect   (new_redirect),
    .new_target     (new_target),
    .redirect_src   (redirect_src),
    .if_flush       (if_flush)
  );

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= RESET_PC_ALIGNED;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (PCWrite) begin
      pc_q          <= next_pc;
      pending_valid <= 1'b0;
      fetch_count   <= fetch_count + 32'd1;
      if (redirect_src != RD_NONE) redirect_count <= redirect_count + 16'd1;
    end else if (new_redirect) begin
      // Stalled: remember the latest redirect; a newer one replaces an older one.
      pending_target <= new_target;
      pending_valid  <= 1'b1;
    end
  end

  assign PC            = pc_q;
  assign ImemAddr      = pc_q[IMEM_AW+1:2];
  assign PCplus4       = pc_plus4;
  assign IF_flush      = if_flush;
  assign FetchCount    = fetch_count;
  assign RedirectCount = redirect_count;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of IF_ID. Owns the architectural PC register and produces the instruction-memory word address. Feeds PC+4 into IF_ID.PCin.
- Applies branch and jump redirects resolved in ID. Holds the PC under a load-use stall. Raises IF_flush so IF_ID squashes the wrong-path instruction.
- A redirect that arrives during a stall is held in a pending register, not lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored.
- IMEM_AW, 5, instruction-memory word-address width (32-entry InstMem).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = PC may advance; 0 = stall, hold PC (from hazard unit).
- BranchTaken  in  1  ID-resolved taken branch this cycle.
- BranchTarget  in  32  branch target from ID.
- Jump  in  1  ID-decoded j instruction this cycle.
- JumpIndex  in  26  instr[25:0] (IF_ID raJump).
- JumpPCHi  in  4  PC+4[31:28] of the jump (IF_ID PC4).
- PC  out  32  current fetch PC.
- ImemAddr  out  IMEM_AW  PC[IMEM_AW+1:2], to InstMem.
- PCplus4  out  32  PC+4, to IF_ID.PCin.
- IF_flush  out  1  squash IF_ID contents this cycle.
- FetchCount  out  32  count of PC advances.
- RedirectCount  out  16  count of applied redirects.

Behaviour:
- Reset (async, reset_n=0):
  - PC = {RESET_PC[31:2],2'b00}.
  - pending_valid = 0, pending_target = 0.
  - FetchCount = 0, RedirectCount = 0.
  - IF_flush = 0 while in reset.
- Targets:
  - jump_target = {JumpPCHi, JumpIndex, 2'b00}.
  - br_target = {BranchTarget[31:2], 2'b00}.
- Redirect priority (combinational): BranchTaken > Jump > pending. If BranchTaken and Jump are both high, the branch wins and the jump is dropped.
- PCplus4 = PC + 4, modulo 2^32. 32'hFFFF_FFFC + 4 = 0.
- Per rising edge, PCWrite=1:
  - If a new redirect (BranchTaken or Jump) is present: PC ← new target; pending_valid ← 0; RedirectCount++.
  - Else if pending_valid: PC ← pending_target; pending_valid ← 0; RedirectCount++.
  - Else: PC ← PCplus4.
  - FetchCount++ in all three cases.
- Per rising edge, PCWrite=0:
  - PC holds; counters hold.
  - If a new redirect is present, pending_target ← selected target and pending_valid ← 1. A newer redirect overwrites an older pending one.
- IF_flush (combinational) = PCWrite & (BranchTaken | Jump | pending_valid). It is asserted in exactly the cycle whose edge applies the redirect. It is never asserted while PCWrite=0, because IF_ID holds during a stall.
- Latency: a redirect asserted in cycle n with PCWrite=1 puts the target on PC after edge n. There is one squashed slot (the flush).
- Counters wrap silently: FetchCount at 2^32, RedirectCount at 2^16.
- ImemAddr is derived from the registered PC only. It has no combinational path from the redirect inputs.
- Reset mid-stall clears pending_valid; fetch restarts at RESET_PC.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC default;
  - PC_INC = 4;
  - JUMP_IDX_W = 26;
  - a redirect-source enum {RD_NONE, RD_BRANCH, RD_JUMP, RD_PENDING}.
- One natural sub-module, pc_redirect_sel: combinational priority mux producing next_pc, redirect_src and IF_flush. The top-level if_fetch_stage holds the PC, pending and counter registers.

Test Plan:
- Reset and sequential fetch: reset_n low at t=0, release, PCWrite=1 for 4 edges → PC 0,4,8,C,10; ImemAddr 0..4; FetchCount=4; IF_flush=0.
- Branch redirect: at PC=8, BranchTaken=1, BranchTarget=32'h40 for one cycle → IF_flush=1 that cycle; next PC=40; RedirectCount=1.
- Jump redirect: at PC=32'h40, Jump=1, JumpPCHi=4'h0, JumpIndex=26'h5 → PC=32'h14 next edge; IF_flush=1 for one cycle.
- Stall with pending redirect:
  - At PC=C, PCWrite=0 for 2 edges and BranchTaken=1, BranchTarget=32'h80 in the first stalled cycle → PC stays C, IF_flush=0, FetchCount unchanged.
  - Then PCWrite=1 with no new redirect → IF_flush=1, PC=80 after the edge, pending_valid cleared.
- Simultaneous branch and jump: BranchTaken=1 (target 32'h20), Jump=1 (index 26'h100) → PC=20; RedirectCount increments by 1 only.
- Wrap and async reset:
  - PC forced via RESET_PC=32'hFFFF_FFF8 → after 2 edges PC=0.
  - Assert reset_n mid-cycle with pending_valid=1 → PC=RESET_PC immediately, without waiting for a clock edge; pending cleared; no flush after release.
